// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider.
// Each channel produces a 50% duty square wave (slow_clk) whose half-period is
// div_act clk cycles, plus a one-cycle tick on every slow_clk edge. Divisor
// writes land in a shadow register and are promoted at the next terminal count,
// so a running half-period is never cut short.
//
// Ports:
//   clk, rst       - system clock (rising edge), asynchronous active-high reset
//   cfg_we         - divisor write strobe
//   cfg_ch         - channel index for the write
//   cfg_div        - new half-period in clk cycles (0 is rejected)
//   ch_en          - per-channel run enable
//   sync_restart   - realign all channels to phase 0
//   slow_clk       - divided clocks
//   tick           - one-cycle strobe on each slow_clk edge
//   cfg_err        - one-cycle pulse after a rejected write
module multi_clock_divider #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 250000,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] slow_clk,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  div_act [NUM_CH];
  logic [CNT_W-1:0]  div_shd [NUM_CH];
  logic [NUM_CH-1:0] pend;

  logic              cfg_ok_c;
  logic [NUM_CH-1:0] wr_hit_c;
  logic [NUM_CH-1:0] tc_c;

  // Write qualification, per-channel write decode and terminal-count detect
  always_comb begin
    cfg_ok_c = cfg_we && (cfg_div != '0) && (32'(cfg_ch) < NUM_CH);
    wr_hit_c = '0;
    tc_c     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit_c[i] = cfg_ok_c && (cfg_ch == CH_W'(i));
      // div_act is never 0, so the subtraction cannot underflow
      tc_c[i]     = (cnt[i] == (div_act[i] - CNT_W'(1)));
    end
  end

  // Per-channel counters, divisor promotion and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err  <= 1'b0;
      slow_clk <= '0;
      tick     <= '0;
      pend     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]     <= '0;
        div_act[i] <= DEF_DIV;
        div_shd[i] <= DEF_DIV;
      end
    end else begin
      cfg_err <= cfg_we && !cfg_ok_c;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_restart) begin
          // Restart applies any pending or same-cycle divisor immediately
          cnt[i]      <= '0;
          slow_clk[i] <= 1'b0;
          tick[i]     <= 1'b0;
          pend[i]     <= 1'b0;
          if (wr_hit_c[i]) begin
            div_act[i] <= cfg_div;
            div_shd[i] <= cfg_div;
          end else begin
            div_act[i] <= div_shd[i];
          end
        end else if (!ch_en[i]) begin
          // Idle channel: no half-period to protect, so divisors apply at once
          cnt[i]      <= '0;
          slow_clk[i] <= 1'b0;
          tick[i]     <= 1'b0;
          if (wr_hit_c[i]) begin
            div_act[i] <= cfg_div;
            div_shd[i] <= cfg_div;
            pend[i]    <= 1'b0;
          end else if (pend[i]) begin
            div_act[i] <= div_shd[i];
            pend[i]    <= 1'b0;
          end
        end else if (tc_c[i]) begin
          // Half-period boundary: toggle and pick up the divisor for the next one
          cnt[i]      <= '0;
          slow_clk[i] <= ~slow_clk[i];
          tick[i]     <= 1'b1;
          if (wr_hit_c[i]) begin
            div_act[i] <= cfg_div;
            div_shd[i] <= cfg_div;
            pend[i]    <= 1'b0;
          end else if (pend[i]) begin
            div_act[i] <= div_shd[i];
            pend[i]    <= 1'b0;
          end
        end else begin
          cnt[i]  <= cnt[i] + CNT_W'(1);
          tick[i] <= 1'b0;
          if (wr_hit_c[i]) begin
            div_shd[i] <= cfg_div;
            pend[i]    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: directed scenarios plus random
// traffic, checked every cycle against a countdown-based behavioural model.
module tb_multi_clock_divider;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 24;
  localparam int unsigned DDIV = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_div;
  logic [3:0]    ch_en;
  logic          sync_restart;
  logic [3:0]    slow_clk;
  logic [3:0]    tick;
  logic          cfg_err;

  // Three-channel instance, used only to exercise an out-of-range channel index
  logic          cfg_we3;
  logic [1:0]    cfg_ch3;
  logic [2:0]    slow_clk3;
  logic [2:0]    tick3;
  logic          cfg_err3;

  int n_vec = 0;
  int n_err = 0;
  bit chk3  = 1'b0;

  always #5 clk = ~clk;

  multi_clock_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .ch_en(ch_en), .sync_restart(sync_restart), .slow_clk(slow_clk),
    .tick(tick), .cfg_err(cfg_err)
  );

  multi_clock_divider #(.NUM_CH(3), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div),
    .ch_en(ch_en[2:0]), .sync_restart(sync_restart), .slow_clk(slow_clk3),
    .tick(tick3), .cfg_err(cfg_err3)
  );

  // Behavioural model: cycles remaining until the next toggle per channel
  int       rem [NCH];
  int       act [NCH];
  int       nxt [NCH];   // 0 means no pending divisor
  logic [3:0] m_slow;
  logic [3:0] m_tick;
  logic       m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slow = '0;
      m_tick = '0;
      m_err  = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        rem[c] = DDIV; act[c] = DDIV; nxt[c] = 0;
      end
    end else begin
      int  d;
      bit  wr;
      d = int'(cfg_div);
      m_err = cfg_we && (d == 0);
      for (int c = 0; c < NCH; c++) begin
        wr = cfg_we && (d != 0) && (int'(cfg_ch) == c);
        if (sync_restart) begin
          act[c] = wr ? d : ((nxt[c] != 0) ? nxt[c] : act[c]);
          nxt[c] = 0; m_slow[c] = 1'b0; m_tick[c] = 1'b0; rem[c] = act[c];
        end else if (!ch_en[c]) begin
          if (wr) act[c] = d;
          else if (nxt[c] != 0) act[c] = nxt[c];
          nxt[c] = 0; m_slow[c] = 1'b0; m_tick[c] = 1'b0; rem[c] = act[c];
        end else begin
          rem[c] = rem[c] - 1;
          if (rem[c] == 0) begin
            m_slow[c] = ~m_slow[c];
            m_tick[c] = 1'b1;
            if (wr) act[c] = d;
            else if (nxt[c] != 0) act[c] = nxt[c];
            nxt[c] = 0;
            rem[c] = act[c];
          end else begin
            m_tick[c] = 1'b0;
            if (wr) nxt[c] = d;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("slow_clk", 32'(slow_clk), 32'(m_slow));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    if (chk3) begin
      chk("slow_clk3", 32'(slow_clk3), 32'(m_slow[2:0]));
      chk("tick3", 32'(tick3), 32'(m_tick[2:0]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_div(input logic [1:0] ch, input logic [CW-1:0] d);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; ch_en = 4'hF;
    sync_restart = 1'b0; cfg_we3 = 1'b0; cfg_ch3 = '0;
    cyc(3);
    chk("reset_slow", 32'(slow_clk), 32'h0);
    chk("reset_err", 32'(cfg_err), 32'h0);
    rst = 1'b0; chk3 = 1'b1;

    // First rise after 5 enabled edges, all channels aligned
    cyc(4);
    chk("pre_rise", 32'(slow_clk), 32'h0);
    cyc(1);
    chk("first_rise", 32'(slow_clk), 32'hF);
    chk("first_tick", 32'(tick), 32'hF);
    cyc(1);
    chk("tick_drop", 32'(tick), 32'h0);

    // Out-of-range channel index on the 3-channel instance
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div = 24'd2;
    @(negedge clk);
    cfg_we3 = 1'b0;
    chk("err_bad_ch", 32'(cfg_err3), 32'h1);
    cyc(1);
    chk("err_bad_ch_end", 32'(cfg_err3), 32'h0);
    cyc(12);
    chk3 = 1'b0;

    // Glitch-free update on channel 1 mid half-period
    cyc(2);
    wr_div(2'd1, 24'd3);
    cyc(30);

    // Rejected zero divisor on channel 2
    wr_div(2'd2, 24'd0);
    chk("err_zero", 32'(cfg_err), 32'h1);
    cyc(25);

    // div=1 on channel 3 then restart: clk/2 with tick held high
    wr_div(2'd3, 24'd1);
    sync_restart = 1'b1;
    @(negedge clk);
    sync_restart = 1'b0;
    chk("restart_zero", 32'(slow_clk), 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("div1_tick", 32'(tick[3]), 32'h1);
    end

    // Maximum divisor accepted and runs without toggling early
    wr_div(2'd3, 24'hFFFFFF);
    chk("max_no_err", 32'(cfg_err), 32'h0);
    cyc(40);
    wr_div(2'd3, 24'd5);

    // Drop channel 0 enable mid-count, then re-enable
    cyc(2);
    ch_en[0] = 1'b0;
    @(negedge clk);
    chk("disable_low", 32'(slow_clk[0]), 32'h0);
    cyc(3);
    ch_en[0] = 1'b1;
    cyc(12);

    // Restart together with a write of 7 to channel 2
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 24'd7; sync_restart = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; sync_restart = 1'b0;
    chk("restart_wr_slow", 32'(slow_clk), 32'h0);
    cyc(6);
    chk("ch2_pre7", 32'(slow_clk[2]), 32'h0);
    cyc(1);
    chk("ch2_at7", 32'(slow_clk[2]), 32'h1);
    cyc(25);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      cfg_we       = ($urandom_range(0, 5) == 0);
      cfg_ch       = 2'($urandom_range(0, 3));
      cfg_div      = CW'($urandom_range(0, 9));
      sync_restart = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) ch_en[$urandom_range(0, 3)] ^= 1'b1;
      @(negedge clk);
    end
    cfg_we = 1'b0; sync_restart = 1'b0; ch_en = 4'hF;
    cyc(3);

    // Asynchronous reset between edges clears outputs immediately
    #2 rst = 1'b1;
    #1;
    chk("async_slow", 32'(slow_clk), 32'h0);
    chk("async_tick", 32'(tick), 32'h0);
    chk("async_err", 32'(cfg_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(4);
    chk("post_rst_pre", 32'(slow_clk), 32'h0);
    cyc(1);
    chk("post_rst_rise", 32'(slow_clk), 32'hF);
    cyc(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
